// File: rtl/input_sequencer_pkg.sv
// Shared types and constants for the pushbutton input sequencer.
// Holds command kinds, FSM encodings, default widths and the drop-counter helper.
package input_sequencer_pkg;

    localparam int unsigned PID_W_DEF = 6;
    localparam int unsigned QTY_W_DEF = 4;
    localparam int unsigned KIND_W    = 2;
    localparam int unsigned DROP_W    = 8;

    typedef enum logic [KIND_W-1:0] {
        CMD_NONE = 2'd0,
        CMD_PID  = 2'd1,
        CMD_TXN  = 2'd2
    } cmd_kind_e;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } seq_state_e;

    // Saturating add of up to two lost presses into the drop counter.
    function automatic logic [DROP_W-1:0] sat_add_drop(input logic [DROP_W-1:0] cur,
                                                       input logic [1:0]        inc);
        logic [DROP_W:0] sum;
        sum = (DROP_W+1)'(cur) + (DROP_W+1)'(inc);
        return sum[DROP_W] ? {DROP_W{1'b1}} : sum[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/input_sequencer_debounce_cell.sv
// One pushbutton conditioner: 2-flop synchroniser, stability counter,
// accepted level and a one-cycle rising-edge press pulse.
module input_sequencer_debounce_cell #(
    parameter int unsigned DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic press_c
);

    localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             stable;
    logic             stable_d;
    logic [CNT_W-1:0] cnt;

    // Counter runs only while the synchronised level disagrees with the accepted one,
    // and is cleared at CNT_MAX, so it never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1    <= 1'b0;
            sync2    <= 1'b0;
            stable   <= 1'b0;
            stable_d <= 1'b0;
            cnt      <= '0;
        end else begin
            sync1    <= raw;
            sync2    <= sync1;
            stable_d <= stable;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign press_c = stable & ~stable_d;

endmodule

// File: rtl/input_sequencer.sv
// Conditions the three raw pushbuttons and turns clean presses into a password
// strobe or a latched valid/ready command carrying product ID and quantities.
module input_sequencer
    import input_sequencer_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned PID_W           = PID_W_DEF,
    parameter int unsigned QTY_W           = QTY_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              btn_pass,
    input  logic              btn_pid,
    input  logic              btn_txn,
    input  logic [PID_W-1:0]  product_id_in,
    input  logic [QTY_W-1:0]  dom_items_in,
    input  logic [QTY_W-1:0]  sub_items_in,
    output logic              pass_strobe,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [KIND_W-1:0] cmd_kind,
    output logic [PID_W-1:0]  cmd_product_id,
    output logic [QTY_W-1:0]  cmd_add,
    output logic [QTY_W-1:0]  cmd_sub,
    output logic [DROP_W-1:0] drop_count
);

    logic pass_ev_c;
    logic pid_ev_c;
    logic txn_ev_c;

    input_sequencer_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pass (
        .clk(clk), .rst(rst), .raw(btn_pass), .press_c(pass_ev_c)
    );
    input_sequencer_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_pid (
        .clk(clk), .rst(rst), .raw(btn_pid), .press_c(pid_ev_c)
    );
    input_sequencer_debounce_cell #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_txn (
        .clk(clk), .rst(rst), .raw(btn_txn), .press_c(txn_ev_c)
    );

    logic [PID_W-1:0] pid_s1, pid_s2;
    logic [QTY_W-1:0] add_s1, add_s2;
    logic [QTY_W-1:0] sub_s1, sub_s2;

    // Slide-switch buses are asynchronous to clk as well.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pid_s1 <= '0;
            pid_s2 <= '0;
            add_s1 <= '0;
            add_s2 <= '0;
            sub_s1 <= '0;
            sub_s2 <= '0;
        end else begin
            pid_s1 <= product_id_in;
            pid_s2 <= pid_s1;
            add_s1 <= dom_items_in;
            add_s2 <= add_s1;
            sub_s1 <= sub_items_in;
            sub_s2 <= sub_s1;
        end
    end

    seq_state_e        state, state_next;
    logic [KIND_W-1:0] kind_next;
    logic [PID_W-1:0]  pid_next;
    logic [QTY_W-1:0]  add_next;
    logic [QTY_W-1:0]  sub_next;
    logic [1:0]        drops_c;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pass_strobe    <= 1'b0;
            cmd_valid      <= 1'b0;
            cmd_kind       <= CMD_NONE;
            cmd_product_id <= '0;
            cmd_add        <= '0;
            cmd_sub        <= '0;
            drop_count     <= '0;
        end else begin
            state          <= state_next;
            pass_strobe    <= pass_ev_c;
            cmd_valid      <= (state_next == HOLD);
            cmd_kind       <= kind_next;
            cmd_product_id <= pid_next;
            cmd_add        <= add_next;
            cmd_sub        <= sub_next;
            drop_count     <= sat_add_drop(drop_count, drops_c);
        end
    end

    // Single-entry command slot: accept in IDLE, hold until handshake, drop anything else.
    always_comb begin
        state_next = state;
        kind_next  = cmd_kind;
        pid_next   = cmd_product_id;
        add_next   = cmd_add;
        sub_next   = cmd_sub;
        drops_c    = 2'd0;
        case (state)
            IDLE: begin
                if (pid_ev_c) begin
                    state_next = HOLD;
                    kind_next  = CMD_PID;
                    pid_next   = pid_s2;
                    add_next   = add_s2;
                    sub_next   = sub_s2;
                    drops_c    = 2'(txn_ev_c);
                end else if (txn_ev_c) begin
                    state_next = HOLD;
                    kind_next  = CMD_TXN;
                    pid_next   = pid_s2;
                    add_next   = add_s2;
                    sub_next   = sub_s2;
                end
            end
            HOLD: begin
                drops_c = 2'(pid_ev_c) + 2'(txn_ev_c);
                if (cmd_ready) begin
                    state_next = IDLE;
                    kind_next  = CMD_NONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_input_sequencer.sv
// Directed bench for input_sequencer with DEBOUNCE_CYCLES=4: a vector table of
// single presses plus hand-written sequences for latency, drops, pass and reset.
module tb_input_sequencer;

    logic       clk;
    logic       rst;
    logic       btn_pass, btn_pid, btn_txn;
    logic [5:0] product_id_in;
    logic [3:0] dom_items_in, sub_items_in;
    logic       pass_strobe, cmd_valid, cmd_ready;
    logic [1:0] cmd_kind;
    logic [5:0] cmd_product_id;
    logic [3:0] cmd_add, cmd_sub;
    logic [7:0] drop_count;

    int total = 0;
    int bad   = 0;
    int pass_cnt = 0;

    input_sequencer #(.DEBOUNCE_CYCLES(4), .PID_W(6), .QTY_W(4)) dut (
        .clk(clk), .rst(rst),
        .btn_pass(btn_pass), .btn_pid(btn_pid), .btn_txn(btn_txn),
        .product_id_in(product_id_in), .dom_items_in(dom_items_in), .sub_items_in(sub_items_in),
        .pass_strobe(pass_strobe), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_kind(cmd_kind), .cmd_product_id(cmd_product_id),
        .cmd_add(cmd_add), .cmd_sub(cmd_sub), .drop_count(drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         btn;      // 0 pass, 1 pid, 2 txn
        int         len;
        logic [5:0] id;
        logic [3:0] add;
        logic [3:0] sub;
        logic       e_valid;
        logic [1:0] e_kind;
        logic [5:0] e_id;
        logic [3:0] e_add;
        logic [3:0] e_sub;
        logic [7:0] e_drop;
        int         e_pass;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: sample 1 time unit after the rising edge.
    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (pass_strobe) pass_cnt++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick(2);
        rst = 1'b1;
        tick(1);
    endtask

    task automatic set_btn(input int btn, input logic v);
        case (btn)
            0: btn_pass = v;
            1: btn_pid  = v;
            default: btn_txn = v;
        endcase
    endtask

    // Bouncy txn press; returns the edge index (1 = first stable-high sample) where cmd_valid rose.
    task automatic txn_latency(output int rise_at);
        btn_txn = 1'b1; tick(1);
        btn_txn = 1'b0; tick(1);
        btn_txn = 1'b1; tick(1);
        btn_txn = 1'b0; tick(1);
        btn_txn = 1'b1;
        rise_at = 0;
        for (int k = 1; k <= 12; k++) begin
            tick(1);
            if (rise_at == 0 && cmd_valid) rise_at = k;
        end
        btn_txn = 1'b0;
    endtask

    initial begin
        int rise;
        rst = 1'b0;
        btn_pass = 1'b0; btn_pid = 1'b0; btn_txn = 1'b0;
        product_id_in = '0; dom_items_in = '0; sub_items_in = '0;
        cmd_ready = 1'b0;

        vecs[0] = '{2, 10, 6'b011001, 4'd5, 4'd0, 1'b1, 2'd2, 6'b011001, 4'd5, 4'd0, 8'd0, 0};
        vecs[1] = '{1,  3, 6'h2A, 4'd1, 4'd2, 1'b0, 2'd0, 6'h00, 4'd0, 4'd0, 8'd0, 0};
        vecs[2] = '{1,  4, 6'h2A, 4'd1, 4'd2, 1'b1, 2'd1, 6'h2A, 4'd1, 4'd2, 8'd0, 0};
        vecs[3] = '{2,  2, 6'h11, 4'd3, 4'd3, 1'b0, 2'd0, 6'h00, 4'd0, 4'd0, 8'd0, 0};
        vecs[4] = '{2, 20, 6'h3F, 4'hF, 4'hF, 1'b1, 2'd2, 6'h3F, 4'hF, 4'hF, 8'd0, 0};
        vecs[5] = '{0,  6, 6'h05, 4'd7, 4'd1, 1'b0, 2'd0, 6'h00, 4'd0, 4'd0, 8'd0, 1};
        vecs[6] = '{0,  3, 6'h05, 4'd7, 4'd1, 1'b0, 2'd0, 6'h00, 4'd0, 4'd0, 8'd0, 0};

        tick(2);
        check("reset_valid", 32'(cmd_valid), 32'd0);
        check("reset_kind",  32'(cmd_kind),  32'd0);
        check("reset_drop",  32'(drop_count), 32'd0);
        check("reset_pass",  32'(pass_strobe), 32'd0);
        rst = 1'b1;
        tick(1);

        // Vector table: one isolated press per row, cmd_ready held low.
        for (int i = 0; i < 7; i++) begin
            do_reset();
            product_id_in = vecs[i].id;
            dom_items_in  = vecs[i].add;
            sub_items_in  = vecs[i].sub;
            tick(3);
            pass_cnt = 0;
            set_btn(vecs[i].btn, 1'b1);
            tick(vecs[i].len);
            set_btn(vecs[i].btn, 1'b0);
            tick(15);
            check($sformatf("v%0d_valid", i), 32'(cmd_valid),      32'(vecs[i].e_valid));
            check($sformatf("v%0d_kind", i),  32'(cmd_kind),       32'(vecs[i].e_kind));
            check($sformatf("v%0d_id", i),    32'(cmd_product_id), 32'(vecs[i].e_id));
            check($sformatf("v%0d_add", i),   32'(cmd_add),        32'(vecs[i].e_add));
            check($sformatf("v%0d_sub", i),   32'(cmd_sub),        32'(vecs[i].e_sub));
            check($sformatf("v%0d_drop", i),  32'(drop_count),     32'(vecs[i].e_drop));
            check($sformatf("v%0d_pass", i),  32'(pass_cnt),       32'(vecs[i].e_pass));
        end

        // Bouncy txn press: exact latency, single event, held payload.
        do_reset();
        product_id_in = 6'b011001; dom_items_in = 4'd5; sub_items_in = 4'd0;
        tick(3);
        txn_latency(rise);
        check("lat_edges", 32'(rise), 32'd7);
        tick(10);
        check("lat_valid_hold", 32'(cmd_valid),      32'd1);
        check("lat_kind",       32'(cmd_kind),       32'd2);
        check("lat_id",         32'(cmd_product_id), 32'b011001);
        check("lat_add",        32'(cmd_add),        32'd5);
        check("lat_drop",       32'(drop_count),     32'd0);

        // PID held while txn pressed; switches change in HOLD; then handshake.
        do_reset();
        product_id_in = 6'h15; dom_items_in = 4'd0; sub_items_in = 4'd0;
        tick(3);
        btn_pid = 1'b1; tick(8); btn_pid = 1'b0; tick(4);
        check("hold_valid", 32'(cmd_valid), 32'd1);
        check("hold_kind",  32'(cmd_kind),  32'd1);
        product_id_in = 6'h3F; dom_items_in = 4'd9;
        tick(5);
        check("hold_id_frozen",  32'(cmd_product_id), 32'h15);
        check("hold_add_frozen", 32'(cmd_add),        32'd0);
        btn_txn = 1'b1; tick(20); btn_txn = 1'b0;
        check("hold_drop", 32'(drop_count), 32'd1);
        check("hold_valid_still", 32'(cmd_valid), 32'd1);
        cmd_ready = 1'b1; tick(1); cmd_ready = 1'b0;
        check("xfer_valid", 32'(cmd_valid),      32'd0);
        check("xfer_kind",  32'(cmd_kind),       32'd0);
        check("xfer_id",    32'(cmd_product_id), 32'h15);
        cmd_ready = 1'b1; tick(8); cmd_ready = 1'b0;
        check("idle_ready_valid", 32'(cmd_valid),  32'd0);
        check("idle_ready_drop",  32'(drop_count), 32'd1);

        // pid and txn on the same edge: pid wins, txn counted as dropped.
        do_reset();
        product_id_in = 6'h0C; dom_items_in = 4'd3; sub_items_in = 4'd4;
        tick(3);
        btn_pid = 1'b1; btn_txn = 1'b1; tick(8);
        btn_pid = 1'b0; btn_txn = 1'b0; tick(4);
        check("sim_kind",  32'(cmd_kind),   32'd1);
        check("sim_valid", 32'(cmd_valid),  32'd1);
        check("sim_drop",  32'(drop_count), 32'd1);
        check("sim_add",   32'(cmd_add),    32'd3);
        check("sim_sub",   32'(cmd_sub),    32'd4);

        // Password press while a command is pending.
        pass_cnt = 0;
        btn_pass = 1'b1; tick(8); btn_pass = 1'b0; tick(6);
        check("pass_pulses", 32'(pass_cnt),       32'd1);
        check("pass_valid",  32'(cmd_valid),      32'd1);
        check("pass_kind",   32'(cmd_kind),       32'd1);
        check("pass_id",     32'(cmd_product_id), 32'h0C);
        check("pass_drop",   32'(drop_count),     32'd1);

        // Asynchronous reset mid-HOLD, between clock edges.
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", 32'(cmd_valid),  32'd0);
        check("arst_kind",  32'(cmd_kind),   32'd0);
        check("arst_drop",  32'(drop_count), 32'd0);
        tick(2);
        rst = 1'b1;
        product_id_in = 6'b011001; dom_items_in = 4'd5; sub_items_in = 4'd0;
        tick(3);
        txn_latency(rise);
        check("post_lat_edges", 32'(rise),           32'd7);
        check("post_kind",      32'(cmd_kind),       32'd2);
        check("post_id",        32'(cmd_product_id), 32'b011001);
        check("post_add",       32'(cmd_add),        32'd5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
